// File: rtl/dram_seq_pkg.sv
// Shared types and default widths for the DRAM access sequencer slice.
package dram_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/dram_port_mux.sv
// Combinational RAM port selection between the host loader and the Processor.
module dram_port_mux
  import dram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              proc_owner,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  always_comb begin
    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    ram_we    = host_we;
    if (proc_owner) begin
      ram_addr  = proc_addr;
      ram_wdata = proc_wdata;
      ram_we    = proc_we;
    end
  end

endmodule

// File: rtl/dram_access_sequencer.sv
// Sequences host load / Processor run / host readback on the shared data RAM.
// Optional run statistics outputs: define DRAM_ACCESS_SEQUENCER_STATS_EN.
module dram_access_sequencer
  import dram_seq_pkg::*;
#(
  parameter int unsigned      ADDR_W      = DEFAULT_ADDR_W,
  parameter int unsigned      DATA_W      = DEFAULT_DATA_W,
  parameter int unsigned      TO_W        = 24,
  parameter logic [TO_W-1:0]  RUN_TIMEOUT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              proc_enable,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic              proc_finish,
  output logic [DATA_W-1:0] proc_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              timeout
`ifdef DRAM_ACCESS_SEQUENCER_STATS_EN
  ,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [TO_W-1:0]   stat_cyc
`endif
);

  localparam logic [TO_W-1:0] WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] WD_LAST = RUN_TIMEOUT - WD_ONE;
  localparam logic            WD_EN   = (RUN_TIMEOUT != '0);

  seq_state_t        state, state_nxt;
  logic              ack_pend;
  logic [DATA_W-1:0] rdata_hold;
  logic [TO_W-1:0]   wd;
  logic              start_go, host_owns, accept, wd_hit;

  assign start_go  = (state == IDLE) && start;
  assign host_owns = (state == IDLE) || (state == DONE);
  // Gating with rst keeps the RAM write strobe low during a reset cycle.
  assign accept    = host_req && host_owns && !ack_pend && !start_go && !rst;
  assign wd_hit    = WD_EN && (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (proc_finish || wd_hit) state_nxt = DONE;
      DONE:    if (clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_pend   <= 1'b0;
      rdata_hold <= '0;
      wd         <= '0;
      timeout    <= 1'b0;
    end else begin
      ack_pend <= accept;
      if (ack_pend) rdata_hold <= ram_rdata;
      if (start_go) begin
        wd      <= '0;
        timeout <= 1'b0;
      end else if (state == RUN) begin
        if (wd != '1) wd <= wd + WD_ONE;
        if (wd_hit && !proc_finish) timeout <= 1'b1;
      end
    end
  end

  // RAM output is already registered, so during the ack cycle it is passed
  // straight through; the hold register keeps the last value afterwards.
  assign host_ack    = ack_pend;
  assign host_rdata  = ack_pend ? ram_rdata : rdata_hold;
  assign proc_rdata  = ram_rdata;
  assign proc_enable = (state == RUN);
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  dram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .proc_owner (state == RUN),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (accept && host_we),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_we    (proc_write && !rst),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we)
  );

`ifdef DRAM_ACCESS_SEQUENCER_STATS_EN
  localparam logic [15:0] ST_ONE = 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_cyc <= '0;
    end else if (start_go) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_cyc <= '0;
    end else if (state == RUN) begin
      if (proc_read && stat_rd != '1)  stat_rd  <= stat_rd + ST_ONE;
      if (proc_write && stat_wr != '1) stat_wr  <= stat_wr + ST_ONE;
      if (stat_cyc != '1)              stat_cyc <= stat_cyc + WD_ONE;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = proc_read;
`endif

endmodule

// File: tb/tb_dram_access_sequencer.sv
// Directed self-checking bench for dram_access_sequencer with a behavioural RAM.
module tb_dram_access_sequencer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 24;

  logic          clk = 1'b0;
  logic          rst, start, clear, host_req, host_we;
  logic [AW-1:0] host_addr, proc_addr, ram_addr;
  logic [DW-1:0] host_wdata, host_rdata, proc_wdata, proc_rdata, ram_wdata, ram_rdata;
  logic          host_ack, proc_enable, proc_read, proc_write, proc_finish;
  logic          ram_we, busy, done, timeout;
`ifdef DRAM_ACCESS_SEQUENCER_STATS_EN
  logic [15:0]   stat_rd, stat_wr;
  logic [TW-1:0] stat_cyc;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [DW-1:0] mem [0:65535];

  always #5 clk = ~clk;

  dram_access_sequencer #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TO_W        (TW),
    .RUN_TIMEOUT (24'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .proc_enable (proc_enable),
    .proc_addr   (proc_addr),
    .proc_wdata  (proc_wdata),
    .proc_read   (proc_read),
    .proc_write  (proc_write),
    .proc_finish (proc_finish),
    .proc_rdata  (proc_rdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
`ifdef DRAM_ACCESS_SEQUENCER_STATS_EN
    ,
    .stat_rd     (stat_rd),
    .stat_wr     (stat_wr),
    .stat_cyc    (stat_cyc)
`endif
  );

  // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_we === 1'b1) begin
      mem[ram_addr] <= ram_wdata;
      wr_count++;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int lat, output logic [DW-1:0] rd);
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (host_ack === 1'b1) begin
        lat = i;
        rd  = host_rdata;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; proc_addr = '0; proc_wdata = '0;
    proc_read = 1'b0; proc_write = 1'b0; proc_finish = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (proc_enable !== 1'b0) begin n_fail++; $display("FAIL reset_proc_enable: got %b want 0", proc_enable); end
    n_checks++; if (host_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_host_ack: got %b want 0", host_ack); end
    n_checks++; if (ram_we !== 1'b0)      begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (timeout !== 1'b0)     begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_checks++; if (host_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_host_rdata: got %h want 00", host_rdata); end
  endtask

  task automatic test_load_readback();
    int lat;
    logic [DW-1:0] rd;
    host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'hA5; host_req = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b1)        begin n_fail++; $display("FAIL wr_accept_we: got %b want 1", ram_we); end
    n_checks++; if (ram_addr !== 16'h0010)  begin n_fail++; $display("FAIL wr_accept_addr: got %h want 0010", ram_addr); end
    wait_ack(lat, rd);
    n_checks++; if (lat !== 1)              begin n_fail++; $display("FAIL wr_ack_latency: got %0d want 1", lat); end
    n_checks++; if (mem[16'h0010] !== 8'hA5) begin n_fail++; $display("FAIL wr_ram_data: got %h want a5", mem[16'h0010]); end
    tick();
    n_checks++; if (host_ack !== 1'b0)      begin n_fail++; $display("FAIL ack_one_cycle: got %b want 0", host_ack); end
    host_we = 1'b0; host_addr = 16'h0010; host_req = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0)        begin n_fail++; $display("FAIL rd_accept_we: got %b want 0", ram_we); end
    wait_ack(lat, rd);
    n_checks++; if (lat !== 1)              begin n_fail++; $display("FAIL rd_ack_latency: got %0d want 1", lat); end
    n_checks++; if (rd !== 8'hA5)           begin n_fail++; $display("FAIL rd_data: got %h want a5", rd); end
    n_checks++; if (proc_enable !== 1'b0)   begin n_fail++; $display("FAIL load_proc_enable: got %b want 0", proc_enable); end
  endtask

  task automatic test_full_run();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL run_busy_c1: got %b want 1", busy); end
    n_checks++; if (proc_enable !== 1'b1) begin n_fail++; $display("FAIL run_enable_c1: got %b want 1", proc_enable); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL run_clear_ignored: got %b want 1", busy); end
    proc_addr = 16'h0010; proc_read = 1'b1; tick(); proc_read = 1'b0;
    n_checks++; if (proc_rdata !== 8'hA5) begin n_fail++; $display("FAIL run_proc_rdata: got %h want a5", proc_rdata); end
    proc_addr = 16'h0200; proc_wdata = 8'h3C; proc_write = 1'b1; proc_finish = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b1)       begin n_fail++; $display("FAIL run_final_we: got %b want 1", ram_we); end
    n_checks++; if (ram_addr !== 16'h0200) begin n_fail++; $display("FAIL run_final_addr: got %h want 0200", ram_addr); end
    tick(); proc_write = 1'b0; proc_finish = 1'b0;
    n_checks++; if (done !== 1'b1)          begin n_fail++; $display("FAIL fin_done: got %b want 1", done); end
    n_checks++; if (proc_enable !== 1'b0)   begin n_fail++; $display("FAIL fin_enable: got %b want 0", proc_enable); end
    n_checks++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL fin_busy: got %b want 0", busy); end
    n_checks++; if (mem[16'h0200] !== 8'h3C) begin n_fail++; $display("FAIL fin_ram_data: got %h want 3c", mem[16'h0200]); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got done=%b busy=%b want done=1 busy=0", done, busy); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_to_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_host_blocked();
    proc_addr = 16'h0123;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    host_we = 1'b0; host_addr = 16'h0200; host_req = 1'b1;
    for (int c = 3; c <= 20; c++) begin
      if (c == 20) proc_finish = 1'b1;
      n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL blocked_ack_c%0d: got %b want 0", c, host_ack); end
      tick();
    end
    proc_finish = 1'b0;
    n_checks++; if (done !== 1'b1)         begin n_fail++; $display("FAIL blocked_done: got %b want 1", done); end
    n_checks++; if (host_ack !== 1'b0)     begin n_fail++; $display("FAIL blocked_ack_done1: got %b want 0", host_ack); end
    n_checks++; if (ram_addr !== 16'h0200) begin n_fail++; $display("FAIL blocked_accept_addr: got %h want 0200", ram_addr); end
    tick();
    n_checks++; if (host_ack !== 1'b1)     begin n_fail++; $display("FAIL blocked_ack_done2: got %b want 1", host_ack); end
    n_checks++; if (host_rdata !== 8'h3C)  begin n_fail++; $display("FAIL blocked_rdata: got %h want 3c", host_rdata); end
    host_req = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_start_with_req();
    int base;
    base = wr_count;
    host_we = 1'b1; host_addr = 16'h0400; host_wdata = 8'h5A; host_req = 1'b1; start = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sreq_start_wins_we: got %b want 0", ram_we); end
    tick(); start = 1'b0;
    n_checks++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL sreq_busy: got %b want 1", busy); end
    for (int c = 1; c <= 6; c++) begin
      n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL sreq_ack_run_c%0d: got %b want 0", c, host_ack); end
      tick();
    end
    n_checks++; if (wr_count !== base) begin n_fail++; $display("FAIL sreq_no_write_in_run: got %0d want %0d", wr_count, base); end
    proc_finish = 1'b1; tick(); proc_finish = 1'b0;
    n_checks++; if (done !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL sreq_accept_done: got done=%b we=%b want 1 1", done, ram_we); end
    tick();
    n_checks++; if (host_ack !== 1'b1) begin n_fail++; $display("FAIL sreq_ack: got %b want 1", host_ack); end
    host_req = 1'b0;
    n_checks++; if (mem[16'h0400] !== 8'h5A) begin n_fail++; $display("FAIL sreq_ram_data: got %h want 5a", mem[16'h0400]); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_watchdog();
    int n;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    n_checks++; if (n !== 100)            begin n_fail++; $display("FAIL wd_run_cycles: got %0d want 100", n); end
    n_checks++; if (done !== 1'b1)        begin n_fail++; $display("FAIL wd_done: got %b want 1", done); end
    n_checks++; if (timeout !== 1'b1)     begin n_fail++; $display("FAIL wd_timeout: got %b want 1", timeout); end
    n_checks++; if (proc_enable !== 1'b0) begin n_fail++; $display("FAIL wd_enable: got %b want 0", proc_enable); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (timeout !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL wd_sticky: got timeout=%b done=%b want 1 0", timeout, done); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_restart: got timeout=%b busy=%b want 0 1", timeout, busy); end
    proc_finish = 1'b1; tick(); proc_finish = 1'b0;
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL wd_finish_no_timeout: got %b want 0", timeout); end
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int base;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    base = wr_count;
    proc_addr = 16'h0500; proc_wdata = 8'hEE; proc_write = 1'b1; rst = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rstrun_we: got %b want 0", ram_we); end
    tick(); rst = 1'b0; proc_write = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstrun_state: got busy=%b done=%b want 0 0", busy, done); end
    n_checks++; if (proc_enable !== 1'b0) begin n_fail++; $display("FAIL rstrun_enable: got %b want 0", proc_enable); end
    n_checks++; if (host_ack !== 1'b0)    begin n_fail++; $display("FAIL rstrun_ack: got %b want 0", host_ack); end
    n_checks++; if (wr_count !== base)    begin n_fail++; $display("FAIL rstrun_no_write: got %0d want %0d", wr_count, base); end
    host_we = 1'b1; host_addr = 16'h0600; host_wdata = 8'h11; host_req = 1'b1; rst = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rstacc_we: got %b want 0", ram_we); end
    tick(); rst = 1'b0; host_req = 1'b0;
    n_checks++; if (host_ack !== 1'b0) begin n_fail++; $display("FAIL rstacc_ack_dropped: got %b want 0", host_ack); end
    n_checks++; if (wr_count !== base) begin n_fail++; $display("FAIL rstacc_no_write: got %0d want %0d", wr_count, base); end
  endtask

  initial begin
    test_reset();
    test_load_readback();
    test_full_run();
    test_host_blocked();
    test_start_with_req();
    test_watchdog();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/dram_access_sequencer.md
Name: dram_access_sequencer

Overview:
- Owns the single-port data RAM shared between the down-sampling Processor and the host loader (image load and result readback).
- Sequences one processing run: host loads the image, start pulse enables the Processor, the Processor's finish returns RAM ownership to the host for readback.
- Sits between the Processor's memory port (addr_out/dout/din/read/write/finish/enable) and the data RAM.

Parameters:
- ADDR_W, 16, RAM address width; matches Processor addr_out.
- DATA_W, 8, RAM data width; matches Processor din/dout.
- TO_W, 24, width of the run watchdog counter.
- RUN_TIMEOUT, 24'd0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  host pulse; begins a run (honoured in IDLE only).
- clear  in  1  host pulse; DONE -> IDLE.
- host_req  in  1  host RAM access request; held until host_ack.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host RAM address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  DATA_W  read data, valid while host_ack = 1.
- proc_enable  out  1  drives Processor enable.
- proc_addr  in  ADDR_W  Processor addr_out.
- proc_wdata  in  DATA_W  Processor dout.
- proc_read  in  1  Processor read.
- proc_write  in  1  Processor write.
- proc_finish  in  1  Processor finish (level).
- proc_rdata  out  DATA_W  to Processor din.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency.
- busy  out  1  1 in RUN.
- done  out  1  1 in DONE.
- timeout  out  1  sticky; last run ended by the watchdog.

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE.
- Output reset values: proc_enable = 0, host_ack = 0, ram_we = 0, busy = 0, done = 0, timeout = 0, host_rdata = 0, watchdog = 0.
- Ownership:
  - Host owns RAM in IDLE and DONE.
  - Processor owns RAM in RUN: ram_addr = proc_addr, ram_wdata = proc_wdata, ram_we = proc_write, combinationally. proc_rdata = ram_rdata always.
- Host access:
  - Accepted in any cycle with host_req = 1, host-owned state, no pending ack, and not (IDLE and start).
  - Accept cycle: ram_addr = host_addr, ram_we = host_we.
  - Next cycle: host_ack = 1 and host_rdata registered from ram_rdata; write-ack data is don't-care.
  - Throughput: one access per 2 cycles.
  - Requests in RUN are not accepted and not dropped; they wait, with host holding host_req, until DONE.
- Transitions:
  - IDLE + start -> RUN. proc_enable = 1 from the next cycle. Watchdog cleared, timeout cleared.
  - start and host_req in the same IDLE cycle: start wins; the request waits for DONE.
  - An access accepted in the cycle before start still acks normally: the ack cycle overlaps the first RUN cycle, and the RAM read already completed.
  - RUN + proc_finish = 1 -> DONE. proc_enable = 0 from the next cycle. The Processor's final-cycle write (proc_write with finish) is still committed.
  - RUN + watchdog == RUN_TIMEOUT - 1 (RUN_TIMEOUT != 0) -> DONE with timeout = 1.
  - Watchdog increments every RUN cycle and saturates, never wraps.
  - DONE + clear -> IDLE; done = 0. start in DONE is ignored.
  - clear outside DONE is ignored.
- Reset mid-run or mid-access: immediate return to IDLE, proc_enable = 0, pending ack discarded, ram_we = 0 in the reset cycle.

Optional Feature:
- Macro: DRAM_ACCESS_SEQUENCER_STATS_EN.
- With the macro defined:
  - Adds outputs stat_rd[15:0], stat_wr[15:0] and stat_cyc[TO_W-1:0].
  - These count Processor reads, Processor writes and RUN cycles of the current or last run.
  - Cleared on start; saturating; reset to 0.
- Without it: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dram_seq_pkg holds the state enum (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2) and default widths ADDR_W = 16, DATA_W = 8.
- One sub-module: dram_port_mux, the combinational RAM-port selection between host and Processor driven by an owner select.
- FSM, watchdog and ack pipeline stay in the top module.

Test Plan:
- Load and readback in IDLE:
  - Stimulus: host writes 0xA5 to addr 0x0010, then reads 0x0010.
  - Required: each host_ack is exactly 1 cycle after accept; read returns host_rdata = 0xA5; proc_enable stays 0.
- Full run:
  - Stimulus: start; the Processor model writes 0x3C to 0x0200 and asserts proc_finish on the same cycle.
  - Required: busy = 1 from start+1 until finish. RAM[0x0200] = 0x3C. done = 1 and proc_enable = 0 on the cycle after finish.
- Host blocked during RUN:
  - Stimulus: host_req held from RUN cycle 3; Processor finishes at cycle 20.
  - Required: no host_ack before DONE; the request is accepted on the first DONE cycle and acked on the next.
- Simultaneous start and host_req in IDLE:
  - Required: state goes to RUN, no host_ack in RUN, and the access completes after DONE.
- Watchdog:
  - Stimulus: RUN_TIMEOUT = 100; Processor never finishes.
  - Required: DONE entered after exactly 100 RUN cycles; timeout = 1; proc_enable = 0. The next start clears timeout.
- Reset mid-run:
  - Stimulus: rst asserted at RUN cycle 5.
  - Required: next cycle IDLE, proc_enable = 0, busy = 0, host_ack = 0, and no RAM write in the reset cycle.
